// File: rtl/flag_led_array.sv
// Multi-channel status-LED driver: per-channel start/stop state machine with a
// shared free-running blink-phase timer and a retriggerable pulse stretcher.
module flag_led_array #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned CNT_W       = 28,
    parameter int unsigned HALF_PERIOD = 40_000_000,
    parameter int unsigned STRETCH     = 8_000_000
) (
    input  logic            Clk_In,
    input  logic            Rst,
    input  logic [N_CH-1:0] In_Start_Light,
    input  logic [N_CH-1:0] In_Stop_Extinguish,
    input  logic [N_CH-1:0] In_Event,
    input  logic [N_CH-1:0] Cfg_Blink_En,
    output logic [N_CH-1:0] Out_LED,
    output logic [N_CH-1:0] Out_LED_Blink,
    output logic [N_CH-1:0] Out_LED_Pulse
);

    localparam int unsigned IN_W = 3 * N_CH;
    localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] STR_LOAD = CNT_W'(STRETCH);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } ch_state_e;

    logic [IN_W-1:0] in_s1_q, in_s2_q, in_s3_q;
    logic [IN_W-1:0] in_edge_c;
    logic [N_CH-1:0] start_edge_c, stop_edge_c, event_edge_c;

    logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
    logic             phase_q, phase_d;

    ch_state_e        state_q   [N_CH];
    ch_state_e        state_d   [N_CH];
    logic [CNT_W-1:0] str_cnt_q [N_CH];
    logic [CNT_W-1:0] str_cnt_d [N_CH];
    logic [N_CH-1:0]  blink_q, blink_d;
    logic [N_CH-1:0]  pulse_q, pulse_d;

    // Rising edges of the synchronised inputs, split back into their groups
    assign in_edge_c    = in_s2_q & ~in_s3_q;
    assign start_edge_c = in_edge_c[N_CH-1:0];
    assign stop_edge_c  = in_edge_c[2*N_CH-1:N_CH];
    assign event_edge_c = in_edge_c[3*N_CH-1:2*N_CH];

    // Shared phase timer: never cleared by channel activity so all channels blink together
    always_comb begin
        phase_cnt_d = phase_cnt_q + CNT_W'(1);
        phase_d     = phase_q;
        if (phase_cnt_q == PH_LAST) begin
            phase_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    // Per-channel next state, blink and stretch logic; stop beats start
    always_comb begin
        blink_d = '0;
        pulse_d = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            state_d[i]   = state_q[i];
            str_cnt_d[i] = str_cnt_q[i];
            case (state_q[i])
                IDLE:    if (start_edge_c[i] && !stop_edge_c[i]) state_d[i] = ACTIVE;
                ACTIVE:  if (stop_edge_c[i]) state_d[i] = IDLE;
                default: state_d[i] = IDLE;
            endcase
            blink_d[i] = (state_d[i] == ACTIVE) && (Cfg_Blink_En[i] ? phase_d : 1'b1);
            if (event_edge_c[i]) begin
                str_cnt_d[i] = STR_LOAD;
            end else if (str_cnt_q[i] != '0) begin
                str_cnt_d[i] = str_cnt_q[i] - CNT_W'(1);
            end
            pulse_d[i] = (str_cnt_d[i] != '0);
        end
    end

    always_ff @(posedge Clk_In) begin
        if (Rst) begin
            in_s1_q     <= '0;
            in_s2_q     <= '0;
            in_s3_q     <= '0;
            phase_cnt_q <= '0;
            phase_q     <= 1'b1;
            blink_q     <= '0;
            pulse_q     <= '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                state_q[i]   <= IDLE;
                str_cnt_q[i] <= '0;
            end
        end else begin
            in_s1_q     <= {In_Event, In_Stop_Extinguish, In_Start_Light};
            in_s2_q     <= in_s1_q;
            in_s3_q     <= in_s2_q;
            phase_cnt_q <= phase_cnt_d;
            phase_q     <= phase_d;
            blink_q     <= blink_d;
            pulse_q     <= pulse_d;
            for (int i = 0; i < int'(N_CH); i++) begin
                state_q[i]   <= state_d[i];
                str_cnt_q[i] <= str_cnt_d[i];
            end
        end
    end

    always_comb begin
        Out_LED = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            Out_LED[i] = (state_q[i] == ACTIVE);
        end
    end

    assign Out_LED_Blink = blink_q;
    assign Out_LED_Pulse = pulse_q;

endmodule
